sync_down_counter: RTL and testbench
====================================

# sync_down_counter

Synchronous, programmable down counter with terminal-count pulse and optional auto-reload. It complements the ripple up counter: it counts down instead of up, and every bit is clocked from the single `clk`, so there is no cascaded clocking. It serves as the timer/divider primitive for blocks that need a count-down interval, a one-shot delay or a periodic tick. All outputs are registered.

## Interface
- `WIDTH`, default 4: counter and reload width in bits.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load`  in  1  captures `load_val` into the reload register and into `count`.
- `load_val`  in  WIDTH  reload value N.
- `start`  in  1  begins or restarts counting from the reload value.
- `stop`  in  1  halts counting and holds `count`.
- `en`  in  1  count-tick qualifier; RUN advances only on cycles with `en`=1.
- `auto_reload`  in  1  1 = periodic, 0 = one-shot; sampled at terminal count.
- `count`  out  WIDTH  current count value.
- `tc`  out  1  one-cycle terminal-count pulse.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE (one-shot completed).

## Operation
- States: IDLE, RUN, DONE.
- Reset (`rst`=0, async): state IDLE; `count`=0; reload register=0; `tc`=0; `busy`=0; `done`=0.
- Per-edge priority is load > stop > start > count tick.
- `load`, any state:
  - reload←`load_val`, `count`←`load_val`, state←IDLE.
  - `start`, `stop` and the tick are ignored that cycle.
- `stop` in RUN: state←IDLE and `count` holds. In IDLE or DONE it has no effect.
- `start`, any state: `count`←reload and state←RUN. In RUN this is a restart, and a coincident terminal count is discarded (no `tc`).
- Count tick in RUN with `en`=1:
  - `count`≠0: `count`←`count`−1.
  - `count`=0 (terminal): `tc`←1 for exactly one cycle.
  - Terminal with `auto_reload`=1: `count`←reload, stay in RUN.
  - Terminal with `auto_reload`=0: state←DONE, `count` stays 0.
- `en`=0 in RUN: `count` holds and `tc`=0.
- No underflow: `count` never wraps below 0. Modulo-2^WIDTH arithmetic is never exercised.
- Reload=0:
  - Auto-reload: `tc` fires on every `en` cycle, so `tc` stays high continuously with `en` held at 1.
  - One-shot: DONE follows the first tick.
- `busy`=(state==RUN) and `done`=(state==DONE), both registered.
- `tc`=0 on every cycle that has no terminal tick.
- DONE holds `count`=0 until `start` or `load`.

## Timing
- `start` sampled at edge k: after edge k, `busy`=1 and `count`=N.
- With `en` held at 1:
  - `count`=0 after edge k+N.
  - `tc`=1 after edge k+N+1, for one cycle.
- One-shot: `done`=1 and `busy`=0 after edge k+N+1, coincident with `tc`.
- Auto-reload: `tc` period is N+1 `en`-qualified cycles, and `count` shows N again coincident with `tc`.
- `load` takes effect after one edge; `count`=`load_val` is visible the next cycle.
- Reset mid-count: outputs clear immediately, asynchronous to `clk`. Reset release is synchronous-safe: the first edge after deassertion sees IDLE.

## Test plan
- Reset, then `load_val`=5 with `load` pulsed, then `start` with `en`=1, `auto_reload`=0:
  - `count` reads 5,4,3,2,1,0.
  - Next cycle: `tc`=1 for one cycle, `done`=1, `busy`=0, `count` stays 0.
- `load_val`=3, `auto_reload`=1, `en`=1 for 12 cycles: `tc` pulses every 4 cycles, and `count` cycles 3,2,1,0,3,…
- `en` toggled 1,0,1,0 in RUN from N=4: `count` only decrements on `en`=1 cycles, and `tc` arrives after 5 `en` ticks.
- Simultaneous events:
  - `load`+`start` in the same cycle: load wins and the state is IDLE.
  - `stop`+`start` in RUN: the state becomes IDLE with `count` held.
  - `start` at `count`=0 with `auto_reload`=0: restart to N, no `tc`.
- Reload=0 in both modes:
  - Auto-reload: `tc` stays high every cycle with `en`=1.
  - One-shot: a single `tc`, then DONE.
- Assert `rst`=0 mid-count (`count`=2) between edges: `count`=0, `tc`/`busy`/`done`=0 immediately. After release, `start` counts from reload=0.

Source files
------------

// File: rtl/sync_down_counter_if.sv
// Control/status bundle for sync_down_counter: the controller (master) drives
// the load/start/stop/tick inputs; the counter (slave) returns count and flags.
interface sync_down_counter_if #(parameter int WIDTH = 4);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, stop, en, auto_reload,
    input  count, tc, busy, done
  );

  modport slave (
    input  load, load_val, start, stop, en, auto_reload,
    output count, tc, busy, done
  );
endinterface

// File: rtl/sync_down_counter.sv
// Programmable synchronous down counter with one-cycle terminal-count pulse,
// one-shot/periodic modes and fully registered outputs.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  sync_down_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_d;

  // Priority: load > stop (RUN only) > start > count tick.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.load) begin
      reload_d = bus.load_val;
      count_d  = bus.load_val;
      state_d  = IDLE;
    end else if (bus.stop && state_q == RUN) begin
      state_d = IDLE;
    end else if (bus.start) begin
      count_d = reload_q;
      state_d = RUN;
    end else if (state_q == RUN && bus.en) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        if (bus.auto_reload) count_d = reload_q;
        else                 state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      bus.tc   <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      bus.tc   <= tc_d;
      // Flags registered from next state so they line up with state_q.
      bus.busy <= (state_d == RUN);
      bus.done <= (state_d == DONE);
    end
  end

  assign bus.count = count_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter: each step drives inputs, queues the
// expected {count,tc,busy,done} and checks it one edge later.
module tb_sync_down_counter;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_down_counter_if #(.WIDTH(WIDTH)) bus ();
  sync_down_counter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    passed = 0;

  function automatic logic [6:0] pack(int c, bit t, bit b, bit d);
    return {c[WIDTH-1:0], t, b, d};
  endfunction

  task automatic check_head();
    item_t      it;
    logic [6:0] obs;
    if (q.size() == 0) begin
      checks++;
      $error("FAIL scoreboard_empty: got no entry, expected one");
      return;
    end
    it  = q.pop_front();
    obs = {bus.count, bus.tc, bus.busy, bus.done};
    checks++;
    assert (obs === it.exp) passed++;
    else $error("FAIL %s: got cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                it.tag, obs[6:3], obs[2], obs[1], obs[0],
                it.exp[6:3], it.exp[2], it.exp[1], it.exp[0]);
  endtask

  // Drive one cycle of inputs, queue expectation, compare after the edge.
  task automatic step(string tag, bit l, int lv, bit s, bit sp, bit e, bit ar,
                      int c, bit t, bit b, bit d);
    item_t it;
    @(negedge clk);
    bus.load = l; bus.load_val = lv[WIDTH-1:0]; bus.start = s;
    bus.stop = sp; bus.en = e; bus.auto_reload = ar;
    it.tag = tag; it.exp = pack(c, t, b, d);
    q.push_back(it);
    @(posedge clk);
    #1;
    check_head();
  endtask

  initial begin
    item_t it;
    int    ec[12];
    bus.load = 0; bus.load_val = '0; bus.start = 0;
    bus.stop = 0; bus.en = 0; bus.auto_reload = 0;

    #1;
    it.tag = "reset"; it.exp = pack(0, 0, 0, 0); q.push_back(it);
    check_head();
    @(negedge clk); rst = 1'b1;

    // One-shot, N=5
    step("os_load",  1, 5, 0, 0, 0, 0, 5, 0, 0, 0);
    step("os_start", 0, 0, 1, 0, 1, 0, 5, 0, 1, 0);
    for (int i = 4; i >= 0; i--) step("os_cnt", 0, 0, 0, 0, 1, 0, i, 0, 1, 0);
    step("os_tc",    0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    step("os_hold",  0, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    // Auto-reload, N=3: tc every 4 en cycles
    step("ar_load",  1, 3, 0, 0, 0, 1, 3, 0, 0, 0);
    step("ar_start", 0, 0, 1, 0, 1, 1, 3, 0, 1, 0);
    ec = '{2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3};
    for (int i = 0; i < 12; i++)
      step("ar_cnt", 0, 0, 0, 0, 1, 1, ec[i], (i % 4) == 3, 1, 0);
    step("stop_start", 0, 0, 1, 1, 1, 1, 3, 0, 0, 0);

    // en gating, N=4
    step("en_load",  1, 4, 0, 0, 0, 0, 4, 0, 0, 0);
    step("en_start", 0, 0, 1, 0, 1, 0, 4, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      step("en_gate", 0, 0, 0, 0, (i % 2) == 0, 0, 3 - i / 2, 0, 1, 0);
    step("en_tc",    0, 0, 0, 0, 1, 0, 0, 1, 0, 1);

    // Restart at terminal count discards tc
    step("rs_start", 0, 0, 1, 0, 1, 0, 4, 0, 1, 0);
    for (int i = 3; i >= 0; i--) step("rs_cnt", 0, 0, 0, 0, 1, 0, i, 0, 1, 0);
    step("rs_restart", 0, 0, 1, 0, 1, 0, 4, 0, 1, 0);
    step("load_start", 1, 2, 1, 0, 1, 0, 2, 0, 0, 0);

    // Reload = 0
    step("z_load",   1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("z_start",  0, 0, 1, 0, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("z_ar_tc", 0, 0, 0, 0, 1, 1, 0, 1, 1, 0);
    step("z_en0",    0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    step("z_os_tc",  0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    step("z_os_done",0, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    // Async reset mid-count at count=2
    step("mr_load",  1, 5, 0, 0, 0, 0, 5, 0, 0, 0);
    step("mr_start", 0, 0, 1, 0, 1, 0, 5, 0, 1, 0);
    for (int i = 4; i >= 2; i--) step("mr_cnt", 0, 0, 0, 0, 1, 0, i, 0, 1, 0);
    #1 rst = 1'b0;
    #1;
    it.tag = "mid_reset"; it.exp = pack(0, 0, 0, 0); q.push_back(it);
    check_head();
    @(negedge clk); rst = 1'b1;
    step("post_start", 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
    step("post_tc",    0, 0, 0, 0, 1, 0, 0, 1, 0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
